// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// It latches the winning byte, pulses tx_start and tracks tx_busy until the frame ends.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [DATA_W-1:0]          tx_in_o,
  output logic                       tx_start_o,
  input  logic                       tx_busy_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       active_o,
  output logic                       done_o,
  output logic                       err_timeout_o
);

  localparam int unsigned GntW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {StIdle, StGrant, StStart, StWaitBusy, StSending} state_e;

  state_e            state_q, state_d;
  logic [GntW-1:0]   grant_q, grant_d;
  logic [GntW-1:0]   last_q, last_d;
  logic [DATA_W-1:0] tx_in_q, tx_in_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pick_valid;
  logic [GntW-1:0]   pick;
  logic [GntW-1:0]   idx;

  // Scan from the farthest offset down so the nearest valid index after last_q wins.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = GntW'((int'(last_q) + i) % int'(NUM_REQ));
      if (req_valid_i[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tx_in_d = tx_in_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!tx_busy_i && pick_valid) begin
          grant_d = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // The byte is taken even if the requester dropped valid meanwhile.
        tx_in_d = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
        last_d  = grant_q;
        state_d = StStart;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy_i) begin
          state_d = StSending;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSending: begin
        if (!tx_busy_i) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GntW'(NUM_REQ - 1);
      tx_in_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tx_in_q <= tx_in_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o   = (state_q == StGrant) ? (NUM_REQ'(1) << grant_q) : '0;
  assign tx_start_o    = (state_q == StStart);
  assign active_o      = (state_q != StIdle);
  assign tx_in_o       = tx_in_q;
  assign grant_id_o    = grant_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of single frames checked via a scoreboard,
// plus hand-written sequences for external busy and asynchronous reset mid-frame.
module tb_uart_tx_arbiter;

  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_in;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        done;
  logic        err_timeout;

  logic model_busy = 1'b0;
  logic ext_busy   = 1'b0;
  logic never      = 1'b0;
  int   busy_len   = 10;

  int errors = 0;
  int checks = 0;

  assign tx_busy = model_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .BUSY_TIMEOUT(Timeout)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .tx_in_o      (tx_in),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .grant_id_o   (grant_id),
    .active_o     (active),
    .done_o       (done),
    .err_timeout_o(err_timeout)
  );

  // Transmitter model: busy rises one cycle after tx_start and stays up busy_len cycles.
  initial begin : busy_model
    int left;
    bit pend;
    left = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_busy = 1'b0;
        pend       = 0;
      end else if (pend) begin
        model_busy = 1'b1;
        left       = busy_len;
        pend       = 0;
      end else if (model_busy) begin
        left--;
        if (left == 0) model_busy = 1'b0;
      end else if (tx_start && !never) begin
        pend = 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        do_rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        never;
    logic [1:0]  grant;
    logic        timeout;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] data;
    logic       timeout;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Follows one frame from the cycle after stimulus is driven until done or err_timeout.
  task automatic run_frame();
    exp_t e;
    bit   have    = 0;
    bit   fin     = 0;
    int   t_ready = -1;
    int   t_start = -1;
    for (int t = 1; t <= 60 && !fin; t++) begin
      @(negedge clk);
      if (have && t == t_ready + 1) begin
        chk("ready_single", req_ready, 0);
      end else if (have && req_ready != 0) begin
        chk("ready_spurious", req_ready, 0);
      end else if (!have && req_ready != 0) begin
        if (sb.size() == 0) begin
          chk("ready_unexpected", req_ready, 0);
        end else begin
          e       = sb.pop_front();
          have    = 1;
          t_ready = t;
          chk("ready_latency", t, 1);
          chk("ready_onehot", req_ready, 4'b0001 << e.grant);
          chk("grant_id", grant_id, e.grant);
        end
      end
      if (tx_start) begin
        if (!have) begin
          chk("start_before_ready", 1, 0);
        end else begin
          chk("start_latency", t, t_ready + 1);
          chk("tx_in", tx_in, e.data);
          t_start = t;
        end
      end
      if (done || err_timeout) begin
        if (!have) begin
          chk("end_without_grant", 1, 0);
        end else begin
          chk("end_kind", {done, err_timeout}, e.timeout ? 2'b01 : 2'b10);
          chk("tx_in_held", tx_in, e.data);
          chk("active_at_end", active, 0);
          // Pulse appears in the cycle after the last of Timeout WAIT_BUSY cycles.
          if (e.timeout) chk("timeout_delay", t - t_start, Timeout + 1);
        end
        fin = 1;
      end
    end
    if (!fin) chk("frame_bound", 0, 1);
  endtask

  initial begin : main
    int k;
    vecs[0]  = '{1'b1, 4'b0001, 32'h443322A5, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h44332211, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h44332211, 1'b0, 2'd1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 32'h44332211, 1'b0, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 32'h44332211, 1'b0, 2'd3, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 32'h44332211, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 32'h44332211, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 4'b0100, 32'h44332211, 1'b0, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 4'b0100, 32'h5A6B7C8D, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 32'h44332211, 1'b1, 2'd2, 1'b1};
    vecs[11] = '{1'b0, 4'b0100, 32'h44332211, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 4'b1001, 32'hC3B2A190, 1'b0, 2'd3, 1'b0};
    vecs[13] = '{1'b0, 4'b1001, 32'hC3B2A190, 1'b0, 2'd0, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {req_ready, tx_in, tx_start, grant_id, active, done, err_timeout}, 0);
    rst = 1'b0;

    foreach (vecs[j]) begin
      if (vecs[j].do_rst) apply_rst();
      req_valid = vecs[j].valid;
      req_data  = vecs[j].data;
      never     = vecs[j].never;
      sb.push_back('{vecs[j].grant, vecs[j].data[vecs[j].grant*8 +: 8], vecs[j].timeout});
      run_frame();
    end

    // External busy blocks arbitration; grant follows on the edge after it drops.
    never     = 1'b0;
    ext_busy  = 1'b1;
    req_valid = 4'b0010;
    req_data  = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_blocks", {req_ready, active}, 0);
    end
    ext_busy = 1'b0;
    sb.push_back('{2'd1, 8'h22, 1'b0});
    run_frame();

    // Asynchronous reset while SENDING, then requester 0 beats requester 3.
    req_valid = 4'b1000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_start && k < 10);
    chk("pre_reset_start_seen", tx_start, 1);
    chk("pre_reset_grant", grant_id, 3);
    chk("pre_reset_tx_in", tx_in, 8'h44);
    repeat (3) @(negedge clk);
    chk("pre_reset_active", {active, tx_busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {req_ready, tx_in, tx_start, grant_id, active, done, err_timeout},
        0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1001;
    sb.push_back('{2'd0, 8'h11, 1'b0});
    run_frame();

    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("idle_after_tests", {req_ready, active}, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
